uart_char_rx: RTL

UART_CHAR_RX -- requirements
Module: uart_char_rx

---
 rtl/uart_char_rx.sv | 105 ++++++++++
 1 files changed

// File: rtl/uart_char_rx.sv
// UART character receiver: 8N1 framing, 2-flop input synchronizer, mid-bit sampling.
// Emits the last good byte with a one-cycle valid pulse, or a one-cycle frame error pulse.
module uart_char_rx #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] char,
    output logic       char_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] STOP      = 3'd3;
    localparam logic [2:0] WAIT_IDLE = 3'd4;

    localparam logic [7:0] H_LAST = 8'(CLKS_PER_BIT / 2 - 1);
    localparam logic [7:0] B_LAST = 8'(CLKS_PER_BIT - 1);

    logic       sync1;
    logic       rxd_s;
    logic [2:0] state;
    logic [7:0] cnt;
    logic [2:0] idx;
    logic [7:0] shreg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1      <= 1'b1;
            rxd_s      <= 1'b1;
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            shreg      <= '0;
            char       <= '0;
            char_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            sync1      <= rxd;
            rxd_s      <= sync1;
            char_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rxd_s) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    // Half-bit check rejects glitches shorter than the start bit centre
                    if (cnt == H_LAST) begin
                        cnt   <= '0;
                        idx   <= '0;
                        state <= rxd_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DATA: begin
                    if (cnt == B_LAST) begin
                        cnt        <= '0;
                        shreg[idx] <= rxd_s;
                        if (idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                STOP: begin
                    if (cnt == B_LAST) begin
                        cnt <= '0;
                        if (rxd_s) begin
                            char       <= shreg;
                            char_valid <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= WAIT_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                WAIT_IDLE: begin
                    // A held-low line (break) must return high before a new start is accepted
                    if (rxd_s) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule
